bounce_sequencer: RTL
=====================

// Module: bounce_sequencer
// PURPOSE
//  Initiator side of the line_drawer start/done interface: drives ld_start, ld_x0, ld_y0 and
//  ld_slope, and watches ld_x/ld_y/ld_done to keep the ball moving around the play field.
//  On wall contact it snaps the ball to the wall, reflects the slope, and relaunches a new segment.
//  Sits between the game controller (enable) and line_drawer; the pixel path consumes ld_x/ld_y unchanged.
// PARAMETERS
//  X_MIN       10    left wall x
//  X_MAX       629   right wall x
//  Y_MIN       20    top wall y
//  Y_MAX       459   bottom wall y
//  INIT_X      10    launch x (must lie on a wall)
//  INIT_Y      240   launch y
//  INIT_SLOPE  -1    launch slope, signed 4b, nonzero
//  SETTLE      3     cycles ld_start is held low per launch, >=2
// PORTS
//  clk        in   1      system clock, 50 MHz
//  reset      in   1      asynchronous, active-low reset
//  enable     in   1      1 = ball in play; 0 = return to launch state
//  ld_x       in   11s    current pixel x from line_drawer
//  ld_y       in   11s    current pixel y from line_drawer
//  ld_done    in   1      line_drawer reached segment endpoint
//  ld_start   out  1      0 = line_drawer loads endpoint; 1 = draw
//  ld_x0      out  11s    segment start x
//  ld_y0      out  11s    segment start y
//  ld_slope   out  4s     segment slope, never 0
//  hit        out  1      one-cycle pulse per wall bounce
//  bounces    out  8      bounce count, saturates at 255
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; ld_start=0, ld_x0=INIT_X, ld_y0=INIT_Y,
//   ld_slope=INIT_SLOPE (0 is replaced by 1), hit=0, bounces=0, settle counter=0.
//  States: IDLE, LOAD, RUN, BOUNCE. All outputs are registered.
//  IDLE: ld_start=0. If enable=1, go to LOAD with settle counter=0.
//  LOAD: ld_start=0. The counter increments each cycle. When counter==SETTLE-1, go to RUN.
//   ld_x0/ld_y0/ld_slope are stable throughout LOAD.
//  RUN: ld_start=1. Contact test applies only when (ld_x,ld_y) != (ld_x0,ld_y0):
//   x-contact: ld_x<=X_MIN or ld_x>=X_MAX. y-contact: ld_y<=Y_MIN or ld_y>=Y_MAX.
//   On contact or ld_done, latch the snapped point into ld_x0/ld_y0 and go to BOUNCE.
//   Snap: x is clamped to [X_MIN,X_MAX] and y to [Y_MIN,Y_MAX].
//   Corner (x- and y-contact together): y is moved to Y_MIN+1 or Y_MAX-1, so that x-wall
//    handling wins in line_drawer.
//   ld_done with no contact: latch (ld_x,ld_y) as-is and count it as a bounce.
//  BOUNCE (1 cycle): ld_start=0, hit=1, bounces+=1 unless 255.
//   ld_slope <= -ld_slope; -8 maps to +7. Then go to LOAD with counter=0.
//  enable=0 in any state: next cycle go to IDLE, ld_start=0, and reload the INIT values.
//   bounces keeps its value.
//  Contact and enable=0 in the same cycle: enable wins, no hit, no count.
//  hit is 0 in every state except BOUNCE. ld_slope is never 0.
//  Launch latency: enable rising -> ld_start=1 after 1+SETTLE cycles.
//  Bounce latency: contact cycle -> ld_start=1 again after 1+1+SETTLE cycles.
// TESTING
//  1 Reset mid-RUN (reset=0 asynchronous to clk): outputs return to INIT values immediately;
//    hit=0; bounces=0.
//  2 enable=1 after reset: ld_start low for exactly 4 cycles (1 IDLE + 3 LOAD), then high;
//    ld_x0=10, ld_y0=240, ld_slope=-1.
//  3 RUN from (10,240), drive ld_x=629, ld_y=300: one hit pulse; ld_x0=629, ld_y0=300;
//    ld_slope=+1; bounces=1; ld_start low 4 cycles.
//  4 Overshoot: drive ld_x=200, ld_y=470 -> ld_y0=459, ld_x0=200.
//    Corner: ld_x=5, ld_y=10 -> ld_x0=10, ld_y0=21.
//  5 ld_slope=-8 at bounce -> +7. 300 forced bounces -> bounces=255, no wrap.
//  6 enable=0 coincident with contact: no hit, IDLE next cycle, INIT values restored.
//    Bench with real line_drawer: 20 bounces, ball never leaves [10..629]x[20..459].

Source files
------------

// File: rtl/bounce_sequencer.sv
// Initiator for the line_drawer start/done handshake: launches ball segments, detects wall
// contact, snaps the contact point onto the wall, reflects the slope and relaunches.
module bounce_sequencer #(
  parameter int X_MIN      = 10,
  parameter int X_MAX      = 629,
  parameter int Y_MIN      = 20,
  parameter int Y_MAX      = 459,
  parameter int INIT_X     = 10,
  parameter int INIT_Y     = 240,
  parameter int INIT_SLOPE = -1,
  parameter int SETTLE     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [10:0] ld_x,
  input  logic signed [10:0] ld_y,
  input  logic               ld_done,
  output logic               ld_start,
  output logic signed [10:0] ld_x0,
  output logic signed [10:0] ld_y0,
  output logic signed [3:0]  ld_slope,
  output logic               hit,
  output logic [7:0]         bounces
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    BOUNCE = 2'd3
  } state_t;

  localparam logic signed [10:0] x_min_c       = 11'(X_MIN);
  localparam logic signed [10:0] x_max_c       = 11'(X_MAX);
  localparam logic signed [10:0] y_min_c       = 11'(Y_MIN);
  localparam logic signed [10:0] y_max_c       = 11'(Y_MAX);
  localparam logic signed [10:0] init_x_c      = 11'(INIT_X);
  localparam logic signed [10:0] init_y_c      = 11'(INIT_Y);
  localparam logic signed [3:0]  slope_raw_c   = 4'(INIT_SLOPE);
  // A zero slope would stall the ball, so it is replaced by +1.
  localparam logic signed [3:0]  init_slope_c  = (slope_raw_c == 4'sd0) ? 4'sd1 : slope_raw_c;
  localparam logic [7:0]         settle_last_c = 8'(SETTLE - 1);

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] lo,
                                               input logic signed [10:0] hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  // -8 has no positive twin in 4 bits, so it reflects to +7.
  function automatic logic signed [3:0] reflect(input logic signed [3:0] s);
    if (s == 4'sb1000) begin
      return 4'sd7;
    end else begin
      return 4'sd0 - s;
    end
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         cnt_r, cnt_s;
  logic               ld_start_s, hit_s;
  logic signed [10:0] x0_s, y0_s, snap_x_s, snap_y_s;
  logic signed [3:0]  slope_s;
  logic [7:0]         bounces_s;
  logic               moved_s, xc_s, yc_s;

  // Contact detection and snapping of the current pixel onto the wall.
  always_comb begin
    moved_s  = (ld_x != ld_x0) || (ld_y != ld_y0);
    xc_s     = moved_s && ((ld_x <= x_min_c) || (ld_x >= x_max_c));
    yc_s     = moved_s && ((ld_y <= y_min_c) || (ld_y >= y_max_c));
    snap_x_s = clamp(ld_x, x_min_c, x_max_c);
    // In a corner, pull y one pixel off the wall so line_drawer treats it as an x-wall hit.
    if (xc_s && yc_s) begin
      if (ld_y <= y_min_c) begin
        snap_y_s = y_min_c + 11'sd1;
      end else begin
        snap_y_s = y_max_c - 11'sd1;
      end
    end else begin
      snap_y_s = clamp(ld_y, y_min_c, y_max_c);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ld_start_s = 1'b0;
    x0_s       = ld_x0;
    y0_s       = ld_y0;
    slope_s    = ld_slope;
    hit_s      = 1'b0;
    bounces_s  = bounces;
    if (!enable) begin
      state_s = IDLE;
      cnt_s   = 8'd0;
      x0_s    = init_x_c;
      y0_s    = init_y_c;
      slope_s = init_slope_c;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = LOAD;
          cnt_s   = 8'd0;
        end
        LOAD: begin
          if (cnt_r == settle_last_c) begin
            state_s    = RUN;
            cnt_s      = 8'd0;
            ld_start_s = 1'b1;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        RUN: begin
          if (xc_s || yc_s || ld_done) begin
            state_s = BOUNCE;
            x0_s    = snap_x_s;
            y0_s    = snap_y_s;
            slope_s = reflect(ld_slope);
            hit_s   = 1'b1;
            if (bounces != 8'd255) begin
              bounces_s = bounces + 8'd1;
            end else begin
              bounces_s = bounces;
            end
          end else begin
            ld_start_s = 1'b1;
          end
        end
        BOUNCE: begin
          state_s = LOAD;
          cnt_s   = 8'd0;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 8'd0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      ld_start <= 1'b0;
      ld_x0    <= init_x_c;
      ld_y0    <= init_y_c;
      ld_slope <= init_slope_c;
      hit      <= 1'b0;
      bounces  <= 8'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ld_start <= ld_start_s;
      ld_x0    <= x0_s;
      ld_y0    <= y0_s;
      ld_slope <= slope_s;
      hit      <= hit_s;
      bounces  <= bounces_s;
    end
  end

endmodule
